// File: rtl/vga_plot_arbiter_if.sv
// Pixel-write bus between the three renderers and the plot arbiter.
// Requester-side signals are packed per requester index 0..2.
interface vga_plot_arbiter_if #(
    parameter int X_W     = 8,
    parameter int Y_W     = 8,
    parameter int COLOR_W = 3
);
    logic                   enable;
    logic [2:0]             req;
    logic [2:0]             last;
    logic [3*X_W-1:0]       x_in;
    logic [3*Y_W-1:0]       y_in;
    logic [3*COLOR_W-1:0]   color_in;
    logic [2:0]             gnt;
    logic [X_W-1:0]         x;
    logic [Y_W-1:0]         y;
    logic [COLOR_W-1:0]     color;
    logic                   plotPixel;
    logic                   busy;

    modport master (
        output enable, req, last, x_in, y_in, color_in,
        input  gnt, x, y, color, plotPixel, busy
    );

    modport slave (
        input  enable, req, last, x_in, y_in, color_in,
        output gnt, x, y, color, plotPixel, busy
    );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin burst arbiter sharing the VGA adapter's single pixel-write port
// between background clear (0), sprite renderer (1) and text overlay (2).
module vga_plot_arbiter #(
    parameter int X_W       = 8,
    parameter int Y_W       = 8,
    parameter int COLOR_W   = 3,
    parameter int MAX_BURST = 64,
    parameter int STALL_MAX = 15
) (
    input  logic                clk,
    input  logic                resetn,
    vga_plot_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, BURST, RELEASE} state_t;

    state_t             state, state_nxt;
    logic [1:0]         rr_ptr;
    logic [1:0]         idx;
    logic [1:0]         pick;
    logic [2:0]         gnt_r, gnt_nxt;
    logic               busy_r;
    logic [7:0]         beat_cnt, stall_cnt;
    logic               beat, beat_end, stall_end;

    logic [X_W-1:0]     x_p0;
    logic [Y_W-1:0]     y_p0;
    logic [COLOR_W-1:0] color_p0;
    logic [X_W-1:0]     x_p1;
    logic [Y_W-1:0]     y_p1;
    logic [COLOR_W-1:0] color_p1;
    logic               vld_p1;

    function automatic logic [1:0] mod3_add(input logic [1:0] p, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, k};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    // Search order starts just after the last-served requester, so nobody has fixed priority.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [2:0] r);
        logic [1:0] c1, c2;
        c1 = mod3_add(ptr, 2'd1);
        c2 = mod3_add(ptr, 2'd2);
        if (r[c1])      return c1;
        else if (r[c2]) return c2;
        else            return ptr;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign pick      = rr_pick(rr_ptr, bus.req);
    assign beat      = (state == BURST) && |(gnt_r & bus.req);
    assign beat_end  = beat && (bus.last[idx] || (({1'b0, beat_cnt} + 9'd1) >= 9'(MAX_BURST)));
    assign stall_end = (state == BURST) && !beat && (({1'b0, stall_cnt} + 9'd1) >= 9'(STALL_MAX));

    // p0: operand select of the granted requester
    assign x_p0     = bus.x_in[int'(idx)*X_W +: X_W];
    assign y_p0     = bus.y_in[int'(idx)*Y_W +: Y_W];
    assign color_p0 = bus.color_in[int'(idx)*COLOR_W +: COLOR_W];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.enable && |bus.req) state_nxt = BURST;
            BURST:   if (beat_end || stall_end)  state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt = 3'b000;
        case (state)
            IDLE:    if (state_nxt == BURST) gnt_nxt = 3'b001 << pick;
            BURST:   if (state_nxt == BURST) gnt_nxt = gnt_r;
            default: gnt_nxt = 3'b000;
        endcase
    end

    // p1: registered grant, counters and adapter-facing plot outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            rr_ptr    <= 2'd2;
            idx       <= 2'd0;
            gnt_r     <= 3'b000;
            busy_r    <= 1'b0;
            beat_cnt  <= 8'd0;
            stall_cnt <= 8'd0;
            vld_p1    <= 1'b0;
            x_p1      <= '0;
            y_p1      <= '0;
            color_p1  <= '0;
        end else begin
            state  <= state_nxt;
            gnt_r  <= gnt_nxt;
            busy_r <= |gnt_nxt;
            vld_p1 <= beat;

            if (state == IDLE && state_nxt == BURST) begin
                idx       <= pick;
                beat_cnt  <= 8'd0;
                stall_cnt <= 8'd0;
            end else if (beat) begin
                beat_cnt  <= sat_inc(beat_cnt);
                stall_cnt <= 8'd0;
            end else if (state == BURST) begin
                stall_cnt <= sat_inc(stall_cnt);
            end

            if (state == RELEASE) rr_ptr <= idx;

            if (beat) begin
                x_p1     <= x_p0;
                y_p1     <= y_p0;
                color_p1 <= color_p0;
            end
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.busy      = busy_r;
    assign bus.plotPixel = vld_p1;
    assign bus.x         = x_p1;
    assign bus.y         = y_p1;
    assign bus.color     = color_p1;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: behavioural requesters feed a scoreboard
// of expected plots that is drained as the adapter strobe appears.
module tb_vga_plot_arbiter;

    localparam int X_W = 8, Y_W = 8, COLOR_W = 3, MAX_BURST = 64, STALL_MAX = 15;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    vga_plot_arbiter_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)) bus ();

    vga_plot_arbiter #(
        .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W),
        .MAX_BURST(MAX_BURST), .STALL_MAX(STALL_MAX)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    // requester model: beats still to offer, burst length (0 = never last), beat in burst
    int         total [3];
    int         blen  [3];
    int         cib   [3];
    logic [7:0] bx    [3];
    logic [7:0] by    [3];
    logic [2:0] bc    [3];

    logic [2:0]  beat_prev, lastv_prev, prev_gnt;
    logic        last_beat_prev;
    logic [18:0] sb [$];
    int          glog [$];
    int          blog [$];
    int          hlog [$];
    int          cur_beats, cur_hold, plots;
    int          e [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_list(input string tag, input int got[$], input int exp[$]);
        chk({tag, "_len"}, got.size(), exp.size());
        if (got.size() == exp.size())
            foreach (exp[k]) chk(tag, got[k], exp[k]);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < 3; i++) begin
            bus.req[i]  = (total[i] > 0);
            bus.last[i] = (blen[i] != 0) && (cib[i] == blen[i] - 1);
            bus.x_in[i*X_W +: X_W]             = bx[i];
            bus.y_in[i*Y_W +: Y_W]             = by[i];
            bus.color_in[i*COLOR_W +: COLOR_W] = bc[i];
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            total[i] = 0; blen[i] = 0; cib[i] = 0;
            bx[i] = 8'd0; by[i] = 8'd0; bc[i] = 3'd0;
        end
        drive_reqs();
        beat_prev = 3'b000; lastv_prev = 3'b000; prev_gnt = 3'b000;
        last_beat_prev = 1'b0;
        sb.delete();
    endtask

    task automatic clear_logs();
        glog.delete(); blog.delete(); hlog.delete();
        plots = 0; cur_beats = 0; cur_hold = 0;
    endtask

    task automatic tick();
        logic [18:0] ex;
        @(negedge clk);
        chk("plot_strobe", bus.plotPixel, beat_prev != 3'b000);
        if (bus.plotPixel === 1'b1) begin
            plots++;
            if (sb.size() == 0) chk("spurious_plot", 1, 0);
            else begin
                ex = sb.pop_front();
                chk("plot_x", bus.x, ex[18:11]);
                chk("plot_y", bus.y, ex[10:3]);
                chk("plot_color", bus.color, ex[2:0]);
            end
        end
        chk("busy_vs_gnt", bus.busy, bus.gnt != 3'b000);
        chk("gnt_onehot", $onehot0(bus.gnt), 1);
        if (last_beat_prev) chk("gnt_drop_after_last", bus.gnt, 0);
        if (prev_gnt != 3'b000 && bus.gnt != 3'b000) chk("gnt_no_switch", bus.gnt, prev_gnt);

        if (bus.gnt != 3'b000 && prev_gnt == 3'b000) begin
            for (int i = 0; i < 3; i++) if (bus.gnt[i]) glog.push_back(i);
            cur_beats = 0; cur_hold = 0;
        end
        if (bus.gnt != 3'b000) cur_hold++;
        if (bus.gnt == 3'b000 && prev_gnt != 3'b000) begin
            blog.push_back(cur_beats);
            hlog.push_back(cur_hold);
        end

        for (int i = 0; i < 3; i++) if (beat_prev[i]) begin
            total[i]--;
            bx[i]++;
            bc[i]++;
            cib[i] = lastv_prev[i] ? 0 : cib[i] + 1;
        end
        drive_reqs();

        beat_prev      = bus.gnt & bus.req;
        lastv_prev     = bus.last;
        last_beat_prev = |(beat_prev & bus.last);
        for (int i = 0; i < 3; i++) if (beat_prev[i]) begin
            sb.push_back({bx[i], by[i], bc[i]});
            cur_beats++;
        end
        prev_gnt = bus.gnt;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            tick();
            if (total[0] == 0 && total[1] == 0 && total[2] == 0 && bus.gnt == 3'b000 &&
                beat_prev == 3'b000 && bus.plotPixel == 1'b0) break;
        end
        if (n == budget) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_plot", bus.plotPixel, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_x", bus.x, 0);
        chk("rst_y", bus.y, 0);
        chk("rst_color", bus.color, 0);
        clear_model();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        bus.enable = 1'b1;
        clear_model();
        clear_logs();
        do_reset();

        // single burst of four beats from the clear engine
        clear_logs();
        total[0] = 4; blen[0] = 4; bx[0] = 8'd10; by[0] = 8'd5; bc[0] = 3'd3;
        drive_reqs();
        tick();
        chk("t1_gnt_after_req", bus.gnt, 3'b001);
        run_until_idle("t1", 50);
        chk("t1_plots", plots, 4);
        e = '{0};    chk_list("t1_order", glog, e);
        e = '{4};    chk_list("t1_beats", blog, e);
        e = '{4};    chk_list("t1_hold", hlog, e);

        // all three requesting, two-beat bursts, round-robin from requester 0
        do_reset();
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            total[i] = 4; blen[i] = 2; bx[i] = 8'(40 * i); by[i] = 8'(20 + i); bc[i] = 3'(i);
        end
        drive_reqs();
        run_until_idle("t2", 200);
        chk("t2_plots", plots, 12);
        e = '{0, 1, 2, 0, 1, 2}; chk_list("t2_order", glog, e);
        e = '{2, 2, 2, 2, 2, 2}; chk_list("t2_beats", blog, e);

        // forced rotation at MAX_BURST with requester 0 waiting
        clear_logs();
        total[1] = 70; blen[1] = 0; bx[1] = 8'd100; by[1] = 8'd7; bc[1] = 3'd5;
        drive_reqs();
        repeat (10) tick();
        total[0] = 1; blen[0] = 1; cib[0] = 0; bx[0] = 8'd1; by[0] = 8'd2; bc[0] = 3'd6;
        drive_reqs();
        run_until_idle("t3a", 400);
        chk("t3a_plots", plots, 71);
        e = '{1, 0, 1};   chk_list("t3a_order", glog, e);
        e = '{64, 1, 6};  chk_list("t3a_beats", blog, e);

        // forced rotation with nobody else waiting: requester 1 regranted
        clear_logs();
        total[1] = 70; blen[1] = 0; bx[1] = 8'd3; by[1] = 8'd9; bc[1] = 3'd1;
        drive_reqs();
        run_until_idle("t3b", 400);
        chk("t3b_plots", plots, 70);
        e = '{1, 1};   chk_list("t3b_order", glog, e);
        e = '{64, 6};  chk_list("t3b_beats", blog, e);

        // overlay drops req after 3 beats: grant held through STALL_MAX idle cycles
        clear_logs();
        total[2] = 3; blen[2] = 0; bx[2] = 8'd150; by[2] = 8'd119; bc[2] = 3'd7;
        drive_reqs();
        run_until_idle("t4", 100);
        chk("t4_plots", plots, 3);
        e = '{2};      chk_list("t4_order", glog, e);
        e = '{3};      chk_list("t4_beats", blog, e);
        e = '{3 + STALL_MAX}; chk_list("t4_hold", hlog, e);

        // enable gating only applies to new grants
        clear_logs();
        bus.enable = 1'b0;
        total[1] = 3; blen[1] = 3; cib[1] = 0; bx[1] = 8'd60; by[1] = 8'd30; bc[1] = 3'd2;
        drive_reqs();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t5_gnt_held_off", bus.gnt, 3'b000);
        end
        bus.enable = 1'b1;
        tick();
        chk("t5_gnt_on_enable", bus.gnt, 3'b010);
        tick();
        bus.enable = 1'b0;
        run_until_idle("t5", 60);
        chk("t5_plots", plots, 3);
        e = '{3};  chk_list("t5_beats", blog, e);
        bus.enable = 1'b1;

        // asynchronous reset mid-burst, then fresh round-robin start
        clear_logs();
        total[0] = 20; blen[0] = 0; bx[0] = 8'd50; by[0] = 8'd40; bc[0] = 3'd4;
        drive_reqs();
        repeat (3) tick();
        chk("t6_pre_plot", bus.plotPixel, 1);
        chk("t6_pre_busy", bus.busy, 1);
        #2;
        do_reset();
        clear_logs();
        repeat (3) tick();
        total[0] = 1; blen[0] = 1; bx[0] = 8'd11; by[0] = 8'd12; bc[0] = 3'd1;
        total[1] = 1; blen[1] = 1; bx[1] = 8'd21; by[1] = 8'd22; bc[1] = 3'd2;
        drive_reqs();
        run_until_idle("t6", 60);
        chk("t6_plots", plots, 2);
        e = '{0, 1};  chk_list("t6_order", glog, e);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Shares the single pixel-write port of the 160x120 VGA adapter (x, y, colour, plot) between three pixel requesters: background clear, sprite renderer and score/text overlay.
- Grants whole bursts round-robin, so each requester owns the port for a run of consecutive pixels.
- Drives registered x/y/colour/plot outputs straight into the adapter.
- Sits between the renderers and vga_adapter in the top level.

Parameters:
- X_W, 8, width of x coordinate.
- Y_W, 8, width of y coordinate (adapter consumes y[6:0]).
- COLOR_W, 3, colour width.
- MAX_BURST, 64, maximum beats per grant before forced rotation (1..255).
- STALL_MAX, 15, maximum consecutive idle granted cycles before the grant is revoked (1..255).

Ports:
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  asynchronous active-low reset
- enable  in  1  when low, no new grant is issued; an active burst finishes
- req  in  3  per-requester request; bit0 = clear, bit1 = sprite, bit2 = overlay
- last  in  3  per-requester end-of-burst marker, qualified by that requester's beat
- x_in  in  3*X_W  packed x coordinates, requester i at [i*X_W +: X_W]
- y_in  in  3*Y_W  packed y coordinates
- color_in  in  3*COLOR_W  packed colours
- gnt  out  3  registered one-hot grant (all-zero when idle)
- x  out  X_W  registered plot x
- y  out  Y_W  registered plot y
- color  out  COLOR_W  registered plot colour
- plotPixel  out  1  registered write strobe to adapter
- busy  out  1  high while any grant is held

Behaviour:
- Reset (async, resetn=0): state=IDLE; gnt=0; x=0; y=0; color=0; plotPixel=0; busy=0; rr_ptr=2, so requester 0 is searched first; beat_cnt=0; stall_cnt=0. Reset asserted mid-burst aborts it immediately and no further plot is issued.
- Beat definition: a beat is accepted in cycle t when gnt[i] && req[i]. At t+1: plotPixel=1, and x/y/color hold requester i's values sampled at t. Latency is 1 cycle. plotPixel=0 in every cycle following a non-beat cycle.
- States: IDLE, BURST, RELEASE.
- IDLE:
  - If enable && |req, select the first requester with req set, searching rr_ptr+1, rr_ptr+2, rr_ptr (mod 3).
  - Register gnt one-hot for it, set busy=1, clear beat_cnt and stall_cnt, and go to BURST.
  - No beat is accepted in the grant cycle itself; the first beat can occur in the cycle after gnt rises.
- BURST, on each cycle:
  - Beat with last[i]=1, or beat where beat_cnt+1 == MAX_BURST: go to RELEASE.
  - Beat otherwise: beat_cnt+1, stall_cnt=0.
  - No beat (req[i]=0): stall_cnt+1. When stall_cnt reaches STALL_MAX, go to RELEASE with no plot.
  - last is ignored on non-beat cycles.
- RELEASE (exactly 1 cycle): gnt=0, busy=0, rr_ptr=index just served, return to IDLE. There is therefore one dead cycle minimum between bursts, which guarantees a grant edge the requesters can observe.
- enable:
  - Sampled only in IDLE; deasserting it during BURST has no effect on that burst.
  - enable=0 with req pending keeps the block in IDLE with gnt=0.
- Requester contract:
  - A requester must keep req and data stable until it sees its gnt bit and the beat is taken.
  - The beat is taken in every cycle gnt[i]&&req[i]; there is no back-pressure from the adapter.
- Fairness: a continuously requesting requester is granted within 2 bursts of other requesters.
- Simultaneous requests in IDLE are resolved only by rr_ptr order; there is no fixed priority.
- Counter widths: beat_cnt and stall_cnt are 8 bits and saturate at their limits; they never wrap.

Test Plan:
- Reset, then req=3'b001, last[0] asserted on 4th beat, x_in[0]=10..13, y_in[0]=5 -> gnt=001 one cycle after req; exactly 4 plotPixel pulses with x=10,11,12,13 and y=5, each 1 cycle after its beat; gnt=0 in the RELEASE cycle.
- req=3'b111 held, each burst 2 beats with last on beat 2 -> grant order 0,1,2,0,1,2; one dead cycle between bursts; no plot in dead cycles.
- MAX_BURST=64, req[1] held, last never asserted -> 64 plots, then forced release; if req[0] is pending it is granted next, otherwise requester 1 is regranted.
- Granted requester 2 drops req after 3 beats, STALL_MAX=15 -> gnt[2] held 15 idle cycles, then RELEASE; exactly 3 plots total.
- enable=0 with req=3'b010 -> gnt stays 0 indefinitely. Raise enable -> gnt=010 next cycle. Drop enable mid-burst -> burst completes to last.
- Assert resetn=0 asynchronously (between clock edges) mid-burst -> gnt, plotPixel and busy go 0 immediately. After release, req=3'b011 -> requester 0 granted first.
